// File: rtl/axi_lite_master_if.sv
// Command/response port and AXI4-Lite channels seen by the single-outstanding AXI-Lite master.
// The master modport is the bridge itself; the slave modport is whatever sits on the other side.
interface axi_lite_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [STRB_WIDTH-1:0] cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;
  logic                  rsp_timeout;

  logic                  AWvalid;
  logic [ADDR_WIDTH-1:0] AWaddr;
  logic                  AWready;
  logic                  Wvalid;
  logic [DATA_WIDTH-1:0] Wdata;
  logic [STRB_WIDTH-1:0] Wstrb;
  logic                  Wready;
  logic                  Bvalid;
  logic [1:0]            Bresp;
  logic                  Bready;
  logic                  ARvalid;
  logic [ADDR_WIDTH-1:0] ARaddr;
  logic                  ARready;
  logic                  Rvalid;
  logic [DATA_WIDTH-1:0] Rdata;
  logic [1:0]            Rresp;
  logic                  Rready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           AWready, Wready, Bvalid, Bresp, ARready, Rvalid, Rdata, Rresp,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
           AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
           AWready, Wready, Bvalid, Bresp, ARready, Rvalid, Rdata, Rresp,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp, rsp_timeout,
           AWvalid, AWaddr, Wvalid, Wdata, Wstrb, Bready, ARvalid, ARaddr, Rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI transaction and one response.
// A stuck B/R channel produces a SLVERR-style timeout response while the ready stays up to drain the late beat.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input logic               clk,
  input logic               rst,
  axi_lite_master_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_WIDTH  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit TIMEOUT_EN = (TIMEOUT > 0);

  typedef enum logic [2:0] {
    IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP, DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_valid_q, aw_valid_d;
  logic                  w_valid_q, w_valid_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  b_ready_q, b_ready_d;
  logic                  ar_valid_q, ar_valid_d;
  logic                  r_ready_q, r_ready_d;
  logic                  pend_q, pend_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cmd_ready;
  logic expired;
  logic late_hs;

  // cmd_ready is the only combinational output; it is forced low while reset is asserted.
  assign cmd_ready = (state_q == IDLE) && rst;
  assign expired   = TIMEOUT_EN && (cnt_q == CNT_LAST);
  assign late_hs   = pend_q && ((b_ready_q && bus.Bvalid) || (r_ready_q && bus.Rvalid));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    aw_valid_d    = aw_valid_q;
    w_valid_d     = w_valid_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    b_ready_d     = b_ready_q;
    ar_valid_d    = ar_valid_q;
    r_ready_d     = r_ready_q;
    pend_d        = pend_q;
    cnt_d         = cnt_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready) begin
          addr_d  = bus.cmd_addr;
          wdata_d = bus.cmd_wdata;
          wstrb_d = bus.cmd_wstrb;
          if (bus.cmd_write) begin
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
            state_d    = WR_AW_W;
          end else begin
            ar_valid_d = 1'b1;
            state_d    = RD_AR;
          end
        end
      end

      // AW and W complete independently, in either order or together.
      WR_AW_W: begin
        if (aw_valid_q && bus.AWready) begin
          aw_valid_d = 1'b0;
          aw_done_d  = 1'b1;
        end
        if (w_valid_q && bus.Wready) begin
          w_valid_d = 1'b0;
          w_done_d  = 1'b1;
        end
        if (aw_done_d && w_done_d) begin
          b_ready_d = 1'b1;
          cnt_d     = '0;
          state_d   = WR_B;
        end
      end

      WR_B: begin
        if (b_ready_q && bus.Bvalid) begin
          b_ready_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = bus.Bresp;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (expired) begin
          pend_d        = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_AR: begin
        if (ar_valid_q && bus.ARready) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          cnt_d      = '0;
          state_d    = RD_R;
        end
      end

      RD_R: begin
        if (r_ready_q && bus.Rvalid) begin
          r_ready_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = bus.Rdata;
          rsp_resp_d    = bus.Rresp;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if (expired) begin
          pend_d        = 1'b1;
          rsp_valid_d   = 1'b1;
          rsp_write_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A late beat arriving while the timeout response waits is swallowed here.
      RESP: begin
        if (late_hs) begin
          b_ready_d = 1'b0;
          r_ready_d = 1'b0;
          pend_d    = 1'b0;
        end
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = pend_d ? DRAIN : IDLE;
        end
      end

      DRAIN: begin
        if (late_hs) begin
          b_ready_d = 1'b0;
          r_ready_d = 1'b0;
          pend_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      aw_valid_q    <= 1'b0;
      w_valid_q     <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      b_ready_q     <= 1'b0;
      ar_valid_q    <= 1'b0;
      r_ready_q     <= 1'b0;
      pend_q        <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      aw_valid_q    <= aw_valid_d;
      w_valid_q     <= w_valid_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      b_ready_q     <= b_ready_d;
      ar_valid_q    <= ar_valid_d;
      r_ready_q     <= r_ready_d;
      pend_q        <= pend_d;
      cnt_q         <= cnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_write   = rsp_write_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_resp    = rsp_resp_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.AWvalid     = aw_valid_q;
  assign bus.AWaddr      = addr_q;
  assign bus.Wvalid      = w_valid_q;
  assign bus.Wdata       = wdata_q;
  assign bus.Wstrb       = wstrb_q;
  assign bus.Bready      = b_ready_q;
  assign bus.ARvalid     = ar_valid_q;
  assign bus.ARaddr      = addr_q;
  assign bus.Rready      = r_ready_q;
endmodule
